// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and multi-cycle execute hold.
// Optional macro HAZARD_STATS_EN adds saturating StallCnt/FlushCnt/MCCnt statistics outputs.
module hazard_unit_mc #(
  parameter int ADDR_W  = 4,
  parameter int NRP     = 3,
  parameter int MC_LAT  = 4,
  parameter int PC_EXCL = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [NRP*ADDR_W-1:0] RAD,
  input  logic [NRP-1:0]        UseD,
  input  logic [NRP*ADDR_W-1:0] RAE,
  input  logic [ADDR_W-1:0]     WA3E,
  input  logic [ADDR_W-1:0]     WA3M,
  input  logic [ADDR_W-1:0]     WA3W,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegW,
  input  logic                  MemWriteM,
  input  logic [ADDR_W-1:0]     RA2M,
  input  logic                  PCSrcE,
  input  logic                  MCStartE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic [2*NRP-1:0]      ForwardE,
  output logic                  ForwardM,
  output logic                  MCBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           StallCnt,
  output logic [31:0]           FlushCnt,
  output logic [31:0]           MCCnt
`endif
);

  localparam int CNT_W = $clog2(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             ld_stall;
  logic             mc_stall;

  // The PC register (all-ones address) is never a forwarding or load-use source when excluded.
  function automatic logic addr_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a == b) && !((PC_EXCL != 0) && (&a));
  endfunction

  always_comb begin
    ForwardE = '0;
    ld_stall = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      if (addr_match(RAE[i*ADDR_W +: ADDR_W], WA3M) && RegWriteM)
        ForwardE[2*i +: 2] = 2'b10;
      else if (addr_match(RAE[i*ADDR_W +: ADDR_W], WA3W) && RegWriteW)
        ForwardE[2*i +: 2] = 2'b01;
      if (UseD[i] && addr_match(RAD[i*ADDR_W +: ADDR_W], WA3E))
        ld_stall = 1'b1;
    end
    ld_stall = ld_stall && MemtoRegE && RegWriteE;
  end

  assign ForwardM = addr_match(RA2M, WA3W) && MemWriteM && MemtoRegW && RegWriteW;

  // The stall is released in the final BUSY cycle so the op leaves execute on that edge.
  assign mc_stall = !Reset && ((state == IDLE) ? MCStartE : (cnt != '0));
  assign MCBusy   = (state == BUSY);

  assign StallF = mc_stall | ld_stall;
  assign StallD = mc_stall | ld_stall;
  assign StallE = mc_stall;
  assign FlushM = mc_stall;
  assign FlushD = PCSrcE;
  assign FlushE = (ld_stall && !mc_stall) || PCSrcE;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MCStartE) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        default: begin
          if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
          else
            state <= IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
      MCCnt    <= '0;
    end else begin
      if (StallF && !(&StallCnt))
        StallCnt <= StallCnt + 32'd1;
      if (PCSrcE && !(&FlushCnt))
        FlushCnt <= FlushCnt + 32'd1;
      if ((state == IDLE) && MCStartE && !(&MCCnt))
        MCCnt <= MCCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc at default parameters; inputs change on the
// falling edge and outputs are sampled 1 ns later.
module tb_hazard_unit_mc;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [11:0] RAD;
  logic [2:0]  UseD;
  logic [11:0] RAE;
  logic [3:0]  WA3E, WA3M, WA3W, RA2M;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegW, MemWriteM;
  logic        PCSrcE, MCStartE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardM, MCBusy;
  logic [5:0]  ForwardE;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCnt, FlushCnt, MCCnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 CLK = ~CLK;

  hazard_unit_mc dut (
    .CLK(CLK), .Reset(Reset), .RAD(RAD), .UseD(UseD), .RAE(RAE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW), .MemWriteM(MemWriteM),
    .RA2M(RA2M), .PCSrcE(PCSrcE), .MCStartE(MCStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardE(ForwardE), .ForwardM(ForwardM), .MCBusy(MCBusy)
`ifdef HAZARD_STATS_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .MCCnt(MCCnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge; callers then set inputs and settle 1 ns before checking.
  task automatic applyStimulus();
    @(negedge CLK);
  endtask

  task automatic clearInputs();
    RAD = '0; UseD = '0; RAE = '0;
    WA3E = '0; WA3M = '0; WA3W = '0; RA2M = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegW = 0; MemWriteM = 0;
    PCSrcE = 0; MCStartE = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    Reset = 1'b1;
    clearInputs();

    applyStimulus();
    #1;
    checkOutput("rst_mcbusy", MCBusy, 0);
    checkOutput("rst_stalle", StallE, 0);
    checkOutput("rst_flushm", FlushM, 0);
    checkOutput("rst_stallf", StallF, 0);
    // Combinational forwarding keeps working while reset is held.
    RAE[3:0] = 4'd5; WA3M = 4'd5; RegWriteM = 1;
    #1;
    checkOutput("rst_fwd", ForwardE, 6'b000010);

    applyStimulus();
    Reset = 0;
    clearInputs();
    RAE[3:0] = 4'd5; WA3M = 4'd5; RegWriteM = 1; WA3W = 4'd5; RegWriteW = 1;
    #1;
    checkOutput("fwd_m_prio", ForwardE, 6'b000010);
    RegWriteM = 0;
    #1;
    checkOutput("fwd_w", ForwardE, 6'b000001);

    clearInputs();
    RAE[7:4] = 4'd15; WA3M = 4'd15; RegWriteM = 1;
    #1;
    checkOutput("fwd_pc_excl", ForwardE, 6'b000000);
    RAE[7:4] = 4'd7; WA3M = 4'd7; RAE[11:8] = 4'd9; WA3W = 4'd9; RegWriteW = 1;
    #1;
    checkOutput("fwd_multi_port", ForwardE, 6'b011000);

    clearInputs();
    RA2M = 4'd6; WA3W = 4'd6; MemWriteM = 1; MemtoRegW = 1; RegWriteW = 1;
    #1;
    checkOutput("fwdm_hit", ForwardM, 1);
    MemtoRegW = 0;
    #1;
    checkOutput("fwdm_no_load", ForwardM, 0);
    MemtoRegW = 1; RA2M = 4'd15; WA3W = 4'd15;
    #1;
    checkOutput("fwdm_pc_excl", ForwardM, 0);

    clearInputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd3; RAD[11:8] = 4'd3; UseD = 3'b100;
    #1;
    checkOutput("ld_stallf", StallF, 1);
    checkOutput("ld_stalld", StallD, 1);
    checkOutput("ld_flushe", FlushE, 1);
    checkOutput("ld_stalle", StallE, 0);
    UseD = 3'b000;
    #1;
    checkOutput("ld_unused", {StallF, StallD, FlushE}, 3'b000);
    PCSrcE = 1;
    #1;
    checkOutput("br_flush", {FlushD, FlushE, StallF}, 3'b110);

    // Multi-cycle op, MC_LAT=4: three stall cycles, MCBusy on the three cycles after the start edge.
    clearInputs();
    MCStartE = 1;
    #1;
    checkOutput("mc_c0", {StallF, StallE, FlushM, FlushE, MCBusy}, 5'b11100);
    applyStimulus();
    MCStartE = 0;
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd2; RAD[3:0] = 4'd2; UseD = 3'b001;
    #1;
    checkOutput("mc_c1_ld_suppr", {StallF, StallE, FlushM, FlushE, MCBusy}, 5'b11101);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("mc_c2", {StallE, FlushM, MCBusy}, 3'b111);
    applyStimulus();
    MCStartE = 1;
    #1;
    checkOutput("mc_c3_release", {StallE, FlushM, StallF, MCBusy}, 4'b0001);
    applyStimulus();
    MCStartE = 0;
    #1;
    checkOutput("mc_c4_idle", {StallE, MCBusy}, 2'b00);

    // Reset while BUSY with cnt=1.
    MCStartE = 1;
    applyStimulus();
    MCStartE = 0;
    applyStimulus();
    #1;
    checkOutput("mc_pre_rst", {StallE, MCBusy}, 2'b11);
    Reset = 1;
    #1;
    checkOutput("mc_rst_stalle", StallE, 0);
    checkOutput("mc_rst_busy", MCBusy, 0);
`ifdef HAZARD_STATS_EN
    checkOutput("stat_stall_rst", StallCnt, 0);
    checkOutput("stat_flush_rst", FlushCnt, 0);
    checkOutput("stat_mc_rst", MCCnt, 0);
`endif
    applyStimulus();
    Reset = 0;
    MCStartE = 1;
    #1;
    checkOutput("post_rst_start", {StallE, MCBusy}, 2'b10);
    applyStimulus();
    MCStartE = 0;
    #1;
    checkOutput("post_rst_busy", MCBusy, 1);
`ifdef HAZARD_STATS_EN
    checkOutput("stat_mc_one", MCCnt, 1);
    checkOutput("stat_stall_one", StallCnt, 1);
`endif

    budget = 20;
    while (MCBusy && budget > 0) begin
      applyStimulus();
      #1;
      budget--;
    end
    checkOutput("mc_drain", MCBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter ADDR_W, default 4, register address width.
REQ-002 Parameter NRP, default 3, read ports per instruction (Rn, Rm, Rs).
REQ-003 Parameter MC_LAT, default 4, execute-stage cycles of a multi-cycle op; legal range 2..16.
REQ-004 Parameter PC_EXCL, default 1, when 1 address all-ones (R15) never matches for forwarding or load-use.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 Reset  in  1  asynchronous, active-high.
REQ-007 RAD  in  NRP*ADDR_W  Decode read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 UseD  in  NRP  Decode port-valid mask.
REQ-009 RAE  in  NRP*ADDR_W  Execute read addresses, same packing.
REQ-010 WA3E, WA3M, WA3W  in  ADDR_W each  destination addresses in E, M, W.
REQ-011 RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegW, MemWriteM  in  1 each  stage controls.
REQ-012 RA2M  in  ADDR_W  store-data address in M.
REQ-013 PCSrcE  in  1  taken branch resolved in E.
REQ-014 MCStartE  in  1  op in E is multi-cycle.
REQ-015 StallF, StallD, StallE  out  1 each  hold stage registers.
REQ-016 FlushD, FlushE, FlushM  out  1 each  bubble into stage registers.
REQ-017 ForwardE  out  2*NRP  per-port select, port i at bits [2i+1:2i]: 10 from M, 01 from W, 00 regfile.
REQ-018 ForwardM  out  1  store data from W.
REQ-019 MCBusy  out  1  FSM in BUSY.

Function
REQ-020 Match(a,b) SHALL be (a==b) and not (PC_EXCL and a all-ones).
REQ-021 ForwardE[i] SHALL be 10 if Match(RAE_i,WA3M)&RegWriteM, else 01 if Match(RAE_i,WA3W)&RegWriteW, else 00; M has priority.
REQ-022 ForwardM SHALL be Match(RA2M,WA3W)&MemWriteM&MemtoRegW&RegWriteW.
REQ-023 ldstall SHALL be OR over i of UseD[i]&Match(RAD_i,WA3E), ANDed with MemtoRegE&RegWriteE.
REQ-024 FSM states IDLE, BUSY; counter width clog2(MC_LAT).
REQ-025 IDLE & MCStartE: mcstall=1, load cnt=MC_LAT-2, go BUSY.
REQ-026 BUSY & cnt!=0: mcstall=1, cnt decrements.
REQ-027 BUSY & cnt==0: mcstall=0, go IDLE; op leaves E this cycle; MCStartE ignored.
REQ-028 mcstall cycles per op SHALL equal MC_LAT-1; MC_LAT=2 gives one stall cycle then release.
REQ-029 mcstall=1: StallF=StallD=StallE=1, FlushM=1, FlushE=0, ldstall suppressed.
REQ-030 mcstall=0: StallF=StallD=ldstall, StallE=0, FlushM=0.
REQ-031 FlushD=PCSrcE; FlushE=(ldstall&~mcstall)|PCSrcE; PCSrcE with MCStartE SHALL not occur (upstream guarantee), no check.
REQ-032 All outputs except FSM state, counter and statistics SHALL be combinational, zero latency.

Reset
REQ-033 Reset asserted SHALL force IDLE, cnt=0, MCBusy=0, mcstall=0 immediately, including mid-BUSY.
REQ-034 Forward/flush outputs SHALL follow inputs during reset; StallE=0, FlushM=0.
REQ-035 First rising edge after Reset deasserts SHALL sample MCStartE normally.

Configuration
REQ-036 Macro HAZARD_STATS_EN defined: outputs StallCnt, FlushCnt, MCCnt (32 bits each) added; count cycles of StallF=1, cycles of PCSrcE=1, IDLE->BUSY transitions; saturate at all-ones; reset to 0.
REQ-037 HAZARD_STATS_EN undefined: these ports and registers SHALL be absent; all other behaviour identical.

Verification
REQ-038 RAE_0=5, WA3M=5, RegWriteM=1, WA3W=5, RegWriteW=1 -> ForwardE[1:0]=10; RegWriteM=0 -> 01.
REQ-039 PC_EXCL=1, RAE_1=15, WA3M=15, RegWriteM=1 -> ForwardE[3:2]=00.
REQ-040 MemtoRegE=RegWriteE=1, WA3E=3, RAD_2=3, UseD=100 -> StallF=StallD=FlushE=1; UseD=000 -> all 0.
REQ-041 MC_LAT=4, one-cycle MCStartE pulse in IDLE -> StallE=FlushM=1 for exactly 3 cycles, MCBusy=1 for 3 cycles after edge, then IDLE.
REQ-042 Reset pulsed during BUSY cnt=1 -> StallE=0 and MCBusy=0 immediately; HAZARD_STATS_EN: counters read 0.
